// File: rtl/fpadd_result_capture_pkg.sv
// fpadd_result_capture_pkg
// Shared definitions for the FP adder output-capture logic: control state
// encoding, legal pipeline depth bounds and the single-precision result width.
// No ports (package).

package fpadd_result_capture_pkg;

  // Control states of the result-capture FSM.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HOLD      = 2'd1,
    HOLD_SKID = 2'd2
  } state_t;

  // Legal range of cycles from launch to result at the last adder stage.
  localparam int PIPE_DEPTH_MIN = 1;
  localparam int PIPE_DEPTH_MAX = 8;

  // Single-precision result width.
  localparam int RESULT_W = 32;

  // Wide enough to count 0..PIPE_DEPTH_MAX launches in flight.
  localparam int IN_FLIGHT_W = 4;

endpackage

// File: rtl/fpadd_result_capture_pipe_valid_tracker.sv
// pipe_valid_tracker
// Follows launches through a fixed-latency pipeline. A valid bit enters
// stage 0 on each launch and moves one stage per cycle. The module flags an
// arrival when the bit reaches the last stage. A registered counter holds the
// number of launches that have not yet arrived.
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous active-high reset
//   launch    - an operation enters stage 1 this cycle
//   arrival   - the oldest tracked operation is at the last stage this cycle
//   in_flight - launches not yet arrived (0..DEPTH)

module pipe_valid_tracker
  import fpadd_result_capture_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = IN_FLIGHT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             launch,
  output logic             arrival,
  output logic [CNT_W-1:0] in_flight
);

  logic [DEPTH-1:0] vld;

  // Valid shift register. A loop is used so that a depth of 1 needs no
  // special case.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else begin
      vld[0] <= launch;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
      end
    end
  end

  assign arrival = vld[DEPTH-1];

  // This counter always equals popcount(vld). It is registered so that
  // consumers do not need an adder tree.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_flight <= '0;
    end else begin
      case ({launch, arrival})
        2'b10:   in_flight <= in_flight + 1'b1;
        2'b01:   in_flight <= in_flight - 1'b1;
        default: in_flight <= in_flight;
      endcase
    end
  end

endmodule

// File: rtl/fpadd_result_capture.sv
// fpadd_result_capture
// Output side of the pipelined FP adder. The module tracks every operand pair
// launched into the adder and captures each result as it leaves the last
// stage. It holds that result for the consumer under a ready/ack handshake.
// It also reports pipeline occupancy and a sticky overrun flag that is set
// when a result is lost.
// Optional feature: define FPADD_RESULT_SKID_EN to add a one-entry skid
// buffer. Without it, a result that arrives while an earlier one is still
// unacknowledged overwrites the earlier result and raises overrun.
// Ports:
//   clk                   - clock, rising edge
//   rst                   - synchronous active-high reset
//   enable_Pipeline_input - operand pair launched this cycle
//   final_result_in       - last adder stage output
//   ack_output            - consumer accepts result_out (ignored unless ready)
//   result_out            - held result
//   ready                 - result_out valid
//   busy                  - launches in flight or result held
//   in_flight             - launches not yet emerged
//   overrun               - sticky, a result was dropped or overwritten

module fpadd_result_capture
  import fpadd_result_capture_pkg::*;
#(
  parameter int PIPE_DEPTH = 4,
  parameter int W          = RESULT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable_Pipeline_input,
  input  logic [W-1:0]           final_result_in,
  input  logic                   ack_output,
  output logic [W-1:0]           result_out,
  output logic                   ready,
  output logic                   busy,
  output logic [IN_FLIGHT_W-1:0] in_flight,
  output logic                   overrun
);

  state_t state;
  logic   arrival;

`ifdef FPADD_RESULT_SKID_EN
  logic [W-1:0] skid;
`endif

  pipe_valid_tracker #(
    .DEPTH (PIPE_DEPTH),
    .CNT_W (IN_FLIGHT_W)
  ) u_tracker (
    .clk       (clk),
    .rst       (rst),
    .launch    (enable_Pipeline_input),
    .arrival   (arrival),
    .in_flight (in_flight)
  );

  // Capture FSM. ready is set and cleared together with the state, so it is
  // high exactly when the state is not IDLE. An ack in IDLE does nothing,
  // because IDLE never looks at ack_output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      result_out <= '0;
      ready      <= 1'b0;
      overrun    <= 1'b0;
`ifdef FPADD_RESULT_SKID_EN
      skid       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (arrival) begin
            result_out <= final_result_in;
            ready      <= 1'b1;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (ack_output && arrival) begin
            result_out <= final_result_in;
          end else if (ack_output) begin
            ready <= 1'b0;
            state <= IDLE;
          end else if (arrival) begin
`ifdef FPADD_RESULT_SKID_EN
            skid  <= final_result_in;
            state <= HOLD_SKID;
`else
            result_out <= final_result_in;
            overrun    <= 1'b1;
`endif
          end
        end
`ifdef FPADD_RESULT_SKID_EN
        HOLD_SKID: begin
          if (ack_output) begin
            result_out <= skid;
            if (arrival) begin
              skid <= final_result_in;
            end else begin
              state <= HOLD;
            end
          end else if (arrival) begin
            overrun <= 1'b1;
          end
        end
`endif
        default: begin
          state <= IDLE;
          ready <= 1'b0;
        end
      endcase
    end
  end

  // busy depends only on registers, so it has no combinational path from
  // any input.
  assign busy = (in_flight != '0) || (state != IDLE);

endmodule
